// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit adder/subtractor split into STAGES equal chunks.
// Each stage adds one chunk and registers its carry for the next stage.
// A single global enable (ce) advances or freezes the whole pipeline, so
// a stalled result at the output holds everything behind it in place.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_bad_params
    $error("pipe_adder: WIDTH must be a positive multiple of STAGES");
  end

  // Per-stage pipeline registers. a/b carry the operands forward so the
  // upper chunks reach their own stage; res accumulates finished chunks so
  // the lower result bits line up with the last chunk at the output.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic              ovf_q, ovf_d;

  // Inputs seen by each stage (stage 0 sees the ports, others the previous stage).
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_r [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [CHUNK:0]    chunk_sum [STAGES];
  logic              msb_cin;
  logic              ce;

  assign ce        = ~valid_q[LAST] | out_ready;
  assign in_ready  = ce;
  assign out_valid = valid_q[LAST];
  assign sum       = res_q[LAST];
  assign cout      = carry_q[LAST];
  assign ovf       = ovf_q;

  // Route each stage's inputs; subtraction inverts B and the carry in at entry.
  always_comb begin
    src_a[0] = in1;
    src_b[0] = in2 ^ {WIDTH{sub}};
    src_r[0] = '0;
    src_c[0] = cin ^ sub;
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_r[k] = res_q[k-1];
      src_c[k] = carry_q[k-1];
      src_v[k] = valid_q[k-1];
    end
  end

  // Chunk adders and next-state: valids shift on ce, data loads only for valid stages.
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      res_d[k] = res_q[k];
      chunk_sum[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                   + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, src_c[k]};
      if (ce) begin
        valid_d[k] = src_v[k];
        if (src_v[k]) begin
          a_d[k]   = src_a[k];
          b_d[k]   = src_b[k];
          res_d[k] = src_r[k];
          res_d[k][k*CHUNK +: CHUNK] = chunk_sum[k][CHUNK-1:0];
          carry_d[k] = chunk_sum[k][CHUNK];
        end
      end
    end
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c_in.
    msb_cin = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ chunk_sum[LAST][CHUNK-1];
    if (ce && src_v[LAST]) begin
      ovf_d = msb_cin ^ chunk_sum[LAST][CHUNK];
    end
  end

  // Pipeline state; reset clears all stages and discards in-flight operations.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

endmodule
